// File: rtl/ysyx_22041071_pkg.sv
// ysyx_22041071_pkg
//   Shared definitions for the execute stage: datapath width, MDU counter
//   width, ALU_ctrl operation codes, the EX FSM state type and small helpers.
package ysyx_22041071_pkg;

    localparam int XLEN  = 64;
    localparam int MDU_W = 7;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_ADDW = 5'd10;
    localparam logic [4:0] ALU_SUBW = 5'd11;
    localparam logic [4:0] ALU_SLLW = 5'd12;
    localparam logic [4:0] ALU_SRLW = 5'd13;
    localparam logic [4:0] ALU_SRAW = 5'd14;
    localparam logic [4:0] ALU_BEQ  = 5'd16;
    localparam logic [4:0] ALU_BNE  = 5'd17;
    localparam logic [4:0] ALU_BLT  = 5'd18;
    localparam logic [4:0] ALU_BGE  = 5'd19;
    localparam logic [4:0] ALU_BLTU = 5'd20;
    localparam logic [4:0] ALU_BGEU = 5'd21;
    localparam logic [4:0] ALU_MUL  = 5'd22;
    localparam logic [4:0] ALU_MULW = 5'd23;
    localparam logic [4:0] ALU_DIV  = 5'd24;
    localparam logic [4:0] ALU_DIVU = 5'd25;
    localparam logic [4:0] ALU_REM  = 5'd26;
    localparam logic [4:0] ALU_REMU = 5'd27;
    localparam logic [4:0] ALU_DIVW = 5'd28;
    localparam logic [4:0] ALU_REMW = 5'd29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ex_state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic is_mdu_op(input logic [4:0] c);
        return (c >= ALU_MUL) && (c <= ALU_REMW);
    endfunction

endpackage

// File: rtl/ysyx_22041071_mdu.sv
// ysyx_22041071_mdu
//   Iterative multiply/divide unit, XLEN iterations per operation.
//   Only built when YSYX_22041071_MDU_EN is defined.
//   Multiply: shift-add on the (extended) operands; only the low XLEN bits
//   are kept, so signedness does not matter.
//   Divide: restoring divide on magnitudes, signs fixed up on the way out.
// Ports
//   clk, reset : clock, synchronous active-high reset (aborts an operation)
//   start      : launch op with operands a, b
//   op         : ALU_ctrl code (MUL..REMW)
//   done       : high during the final iteration cycle
//   res        : final result, valid from the cycle after done until next start
`ifdef YSYX_22041071_MDU_EN
module ysyx_22041071_mdu
    import ysyx_22041071_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);

    logic             busy;
    logic [MDU_W-1:0] cnt;
    logic [4:0]       op_q;
    logic             is_mul_q, neg_q_q, neg_r_q, div0_q;
    // x_q: multiplicand, or dividend shifting out / quotient shifting in
    // y_q: multiplier, or divisor
    // acc_q: product, or partial remainder
    logic [XLEN-1:0]  x_q, y_q, acc_q, a_orig_q;

    logic             sgn, wop, is_mul, a_neg, b_neg;
    logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag;
    logic [XLEN:0]    trial, diff;
    logic [XLEN-1:0]  quo, rem;

    always_comb begin
        sgn    = (op == ALU_DIV) || (op == ALU_REM) || (op == ALU_DIVW) || (op == ALU_REMW);
        wop    = (op == ALU_MULW) || (op == ALU_DIVW) || (op == ALU_REMW);
        is_mul = (op == ALU_MUL) || (op == ALU_MULW);
        a_ext  = wop ? sext32(a[31:0]) : a;
        b_ext  = wop ? sext32(b[31:0]) : b;
        a_neg  = sgn & a_ext[XLEN-1];
        b_neg  = sgn & b_ext[XLEN-1];
        a_mag  = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_mag  = b_neg ? (~b_ext + 1'b1) : b_ext;
    end

    // Borrow out of the trial subtraction means the divisor did not fit.
    assign trial = {acc_q, x_q[XLEN-1]};
    assign diff  = trial - {1'b0, y_q};
    assign done  = busy && (cnt == MDU_W'(XLEN-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            cnt      <= '0;
            op_q     <= '0;
            is_mul_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            a_orig_q <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            op_q     <= op;
            is_mul_q <= is_mul;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            div0_q   <= (b_ext == '0);
            x_q      <= is_mul ? a_ext : a_mag;
            y_q      <= is_mul ? b_ext : b_mag;
            acc_q    <= '0;
            a_orig_q <= a_ext;
        end else if (busy) begin
            cnt <= cnt + MDU_W'(1);
            if (cnt == MDU_W'(XLEN-1))
                busy <= 1'b0;
            if (is_mul_q) begin
                if (y_q[0])
                    acc_q <= acc_q + x_q;
                x_q <= x_q << 1;
                y_q <= y_q >> 1;
            end else if (diff[XLEN]) begin
                acc_q <= trial[XLEN-1:0];
                x_q   <= {x_q[XLEN-2:0], 1'b0};
            end else begin
                acc_q <= diff[XLEN-1:0];
                x_q   <= {x_q[XLEN-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        quo = neg_q_q ? (~x_q + 1'b1) : x_q;
        rem = neg_r_q ? (~acc_q + 1'b1) : acc_q;
        if (div0_q) begin
            quo = '1;
            rem = a_orig_q;
        end
        case (op_q)
            ALU_MUL:            res = acc_q;
            ALU_MULW:           res = sext32(acc_q[31:0]);
            ALU_DIV, ALU_DIVU:  res = quo;
            ALU_REM, ALU_REMU:  res = rem;
            ALU_DIVW:           res = sext32(quo[31:0]);
            ALU_REMW:           res = sext32(rem[31:0]);
            default:            res = '0;
        endcase
    end

endmodule
`endif

// File: rtl/ysyx_22041071_ex_stage.sv
// ysyx_22041071_ex_stage
//   Execute stage: ALU, branch compare/target, optional iterative MDU and the
//   registered EX->MEM slot, which also feeds the ID forwarding path.
//   Build option YSYX_22041071_MDU_EN: adds the MDU and BUSY/DONE states.
//   Without it, codes 22-29 finish in one cycle with result 0.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   valid4/ready4         ID->EX handshake; bundle PC4, Ins3, Brch2, BImm2,
//                         MEM_W_en2, WB_sel2, ALU_ctrl2, reg_w_en2, rt_data1,
//                         rdest1, src_a, src_b
//   valid5/ready5         EX->MEM handshake; slot PC5, Ins4, result, rt_data2,
//                         rdest1_, reg_w_en3_, MEM_W_en3, WB_sel3
//   brch_taken/brch_target  branch resolution, combinational
//
//   state   | meaning
//   IDLE    | accepting bundles
//   BUSY    | MDU iterating, input stalled
//   DONE    | MDU result ready, waiting for a free slot
module ysyx_22041071_ex_stage
    import ysyx_22041071_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            valid4,
    output logic            ready4,
    input  logic [XLEN-1:0] PC4,
    input  logic [31:0]     Ins3,
    input  logic            Brch2,
    input  logic [11:0]     BImm2,
    input  logic            MEM_W_en2,
    input  logic            WB_sel2,
    input  logic [4:0]      ALU_ctrl2,
    input  logic            reg_w_en2,
    input  logic [XLEN-1:0] rt_data1,
    input  logic [4:0]      rdest1,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            valid5,
    input  logic            ready5,
    output logic [XLEN-1:0] PC5,
    output logic [31:0]     Ins4,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] rt_data2,
    output logic [4:0]      rdest1_,
    output logic            reg_w_en3_,
    output logic            MEM_W_en3,
    output logic            WB_sel3,
    output logic            brch_taken,
    output logic [XLEN-1:0] brch_target
);

    logic            accept, slot_free, bubble, is_mdu, load_alu, br_cmp;
    logic [XLEN-1:0] alu_res;
    logic [31:0]     w_add, w_sub, w_sll, w_srl, w_sra;

    assign bubble    = (Ins3 == 32'd0);
    assign slot_free = ~valid5 | ready5;
    assign accept    = valid4 & ready4;

`ifdef YSYX_22041071_MDU_EN
    ex_state_t       state;
    logic            mdu_done, load_mdu;
    logic [XLEN-1:0] mdu_res;
    logic [XLEN-1:0] pend_pc, pend_rt;
    logic [31:0]     pend_ins;
    logic [4:0]      pend_rdest;
    logic            pend_reg_w_en, pend_mem_w_en, pend_wb_sel;

    // A bubble never launches the MDU, whatever ALU_ctrl2 holds.
    assign is_mdu   = is_mdu_op(ALU_ctrl2) & ~bubble;
    assign ready4   = (state == ST_IDLE) & slot_free;
    assign load_mdu = (state == ST_DONE) & slot_free;

    ysyx_22041071_mdu u_mdu (
        .clk   (clk),
        .reset (reset),
        .start (accept & is_mdu),
        .op    (ALU_ctrl2),
        .a     (src_a),
        .b     (src_b),
        .done  (mdu_done),
        .res   (mdu_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pend_pc       <= '0;
            pend_rt       <= '0;
            pend_ins      <= '0;
            pend_rdest    <= '0;
            pend_reg_w_en <= 1'b0;
            pend_mem_w_en <= 1'b0;
            pend_wb_sel   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept && is_mdu) begin
                    state         <= ST_BUSY;
                    pend_pc       <= PC4;
                    pend_rt       <= rt_data1;
                    pend_ins      <= Ins3;
                    pend_rdest    <= rdest1;
                    pend_reg_w_en <= reg_w_en2;
                    pend_mem_w_en <= MEM_W_en2;
                    pend_wb_sel   <= WB_sel2;
                end
                ST_BUSY: if (mdu_done) state <= ST_DONE;
                ST_DONE: if (slot_free) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign is_mdu = 1'b0;
    assign ready4 = slot_free;
`endif

    assign load_alu = accept & ~is_mdu;

    assign w_add = src_a[31:0] + src_b[31:0];
    assign w_sub = src_a[31:0] - src_b[31:0];
    assign w_sll = src_a[31:0] << src_b[4:0];
    assign w_srl = src_a[31:0] >> src_b[4:0];
    assign w_sra = $signed(src_a[31:0]) >>> src_b[4:0];

    // Branch compares, MDU codes (when handled here) and undefined codes give 0.
    always_comb begin
        alu_res = '0;
        case (ALU_ctrl2)
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_SLL:  alu_res = src_a << src_b[5:0];
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SRL:  alu_res = src_a >> src_b[5:0];
            ALU_SRA:  alu_res = $signed(src_a) >>> src_b[5:0];
            ALU_OR:   alu_res = src_a | src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_ADDW: alu_res = sext32(w_add);
            ALU_SUBW: alu_res = sext32(w_sub);
            ALU_SLLW: alu_res = sext32(w_sll);
            ALU_SRLW: alu_res = sext32(w_srl);
            ALU_SRAW: alu_res = sext32(w_sra);
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        br_cmp = 1'b0;
        case (ALU_ctrl2)
            ALU_BEQ:  br_cmp = (src_a == src_b);
            ALU_BNE:  br_cmp = (src_a != src_b);
            ALU_BLT:  br_cmp = ($signed(src_a) <  $signed(src_b));
            ALU_BGE:  br_cmp = ($signed(src_a) >= $signed(src_b));
            ALU_BLTU: br_cmp = (src_a <  src_b);
            ALU_BGEU: br_cmp = (src_a >= src_b);
            default:  br_cmp = 1'b0;
        endcase
    end

    assign brch_taken  = accept & Brch2 & br_cmp;
    assign brch_target = PC4 + {{(XLEN-13){BImm2[11]}}, BImm2, 1'b0};

    // Slot register: load wins over drain; otherwise everything holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid5     <= 1'b0;
            PC5        <= '0;
            Ins4       <= '0;
            result     <= '0;
            rt_data2   <= '0;
            rdest1_    <= '0;
            reg_w_en3_ <= 1'b0;
            MEM_W_en3  <= 1'b0;
            WB_sel3    <= 1'b0;
        end else if (load_alu) begin
            valid5     <= 1'b1;
            PC5        <= PC4;
            Ins4       <= Ins3;
            result     <= alu_res;
            rt_data2   <= rt_data1;
            rdest1_    <= rdest1;
            reg_w_en3_ <= reg_w_en2 & ~bubble;
            MEM_W_en3  <= MEM_W_en2 & ~bubble;
            WB_sel3    <= WB_sel2;
`ifdef YSYX_22041071_MDU_EN
        end else if (load_mdu) begin
            valid5     <= 1'b1;
            PC5        <= pend_pc;
            Ins4       <= pend_ins;
            result     <= mdu_res;
            rt_data2   <= pend_rt;
            rdest1_    <= pend_rdest;
            reg_w_en3_ <= pend_reg_w_en;
            MEM_W_en3  <= pend_mem_w_en;
            WB_sel3    <= pend_wb_sel;
`endif
        end else if (valid5 && ready5) begin
            valid5 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_ex_stage.sv
module tb_ysyx_22041071_ex_stage;
    import ysyx_22041071_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid4, ready4, Brch2, MEM_W_en2, WB_sel2, reg_w_en2;
    logic [63:0] PC4, rt_data1, src_a, src_b;
    logic [31:0] Ins3;
    logic [11:0] BImm2;
    logic [4:0]  ALU_ctrl2, rdest1;
    logic        valid5, ready5, reg_w_en3_, MEM_W_en3, WB_sel3, brch_taken;
    logic [63:0] PC5, result, rt_data2, brch_target;
    logic [31:0] Ins4;
    logic [4:0]  rdest1_;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22041071_ex_stage dut (
        .clk(clk), .reset(reset), .valid4(valid4), .ready4(ready4), .PC4(PC4),
        .Ins3(Ins3), .Brch2(Brch2), .BImm2(BImm2), .MEM_W_en2(MEM_W_en2),
        .WB_sel2(WB_sel2), .ALU_ctrl2(ALU_ctrl2), .reg_w_en2(reg_w_en2),
        .rt_data1(rt_data1), .rdest1(rdest1), .src_a(src_a), .src_b(src_b),
        .valid5(valid5), .ready5(ready5), .PC5(PC5), .Ins4(Ins4), .result(result),
        .rt_data2(rt_data2), .rdest1_(rdest1_), .reg_w_en3_(reg_w_en3_),
        .MEM_W_en3(MEM_W_en3), .WB_sel3(WB_sel3), .brch_taken(brch_taken),
        .brch_target(brch_target)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle op with ready5=1: result visible after one edge.
    task automatic alu(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input string tag);
        ALU_ctrl2 = c; src_a = a; src_b = b; valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        chk({tag, "_v"}, valid5, 1'b1);
        chk(tag, result, exp);
    endtask

`ifdef YSYX_22041071_MDU_EN
    task automatic mdu(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input string tag);
        int n;
        ALU_ctrl2 = c; src_a = a; src_b = b; valid4 = 1'b1;
        #1;
        chk({tag, "_rdy"}, ready4, 1'b1);
        tick();
        valid4 = 1'b0;
        chk({tag, "_busy_rdy"}, ready4, 1'b0);
        n = 1;
        while (valid5 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, XLEN + 2);
        chk(tag, result, exp);
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1; valid4 = 1'b0; ready5 = 1'b1; PC4 = '0; Ins3 = 32'h0000_0033;
        Brch2 = 1'b0; BImm2 = '0; MEM_W_en2 = 1'b0; WB_sel2 = 1'b0; ALU_ctrl2 = '0;
        reg_w_en2 = 1'b0; rt_data1 = '0; rdest1 = '0; src_a = '0; src_b = '0;
        tick(); tick();
        chk("rst_valid5", valid5, 1'b0);
        chk("rst_result", result, 64'd0);
        chk("rst_pc5", PC5, 64'd0);
        chk("rst_rwen", reg_w_en3_, 1'b0);
        chk("rst_mwen", MEM_W_en3, 1'b0);
        chk("rst_wbsel", WB_sel3, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_ready4", ready4, 1'b1);

        // ADD with full passthrough
        ALU_ctrl2 = ALU_ADD; src_a = 64'd5; src_b = -64'sd3; reg_w_en2 = 1'b1;
        rdest1 = 5'd7; PC4 = 64'h100; rt_data1 = 64'hABC; WB_sel2 = 1'b1; valid4 = 1'b1;
        #1;
        chk("add_rdy_pre", ready4, 1'b1);
        tick();
        valid4 = 1'b0;
        chk("add_v", valid5, 1'b1);
        chk("add_res", result, 64'd2);
        chk("add_pc5", PC5, 64'h100);
        chk("add_rd", rdest1_, 5'd7);
        chk("add_rwen", reg_w_en3_, 1'b1);
        chk("add_rt", rt_data2, 64'hABC);
        chk("add_wbsel", WB_sel3, 1'b1);
        chk("add_rdy_post", ready4, 1'b1);
        WB_sel2 = 1'b0;

        alu(ALU_SUB,  64'd10, 64'd3, 64'd7, "sub");
        alu(ALU_SLL,  64'd1, 64'h43, 64'd8, "sll");
        alu(ALU_SLT,  -64'sd1, 64'd1, 64'd1, "slt");
        alu(ALU_SLTU, -64'sd1, 64'd1, 64'd0, "sltu");
        alu(ALU_XOR,  64'hF0, 64'hFF, 64'h0F, "xor");
        alu(ALU_SRL,  64'h8000_0000_0000_0000, 64'd63, 64'd1, "srl");
        alu(ALU_SRA,  64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, "sra");
        alu(ALU_OR,   64'hF0, 64'h0F, 64'hFF, "or");
        alu(ALU_AND,  64'hF0, 64'h3C, 64'h30, "and");
        alu(ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, "addw");
        alu(ALU_SUBW, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "subw");
        alu(ALU_SLLW, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, "sllw");
        alu(ALU_SLLW, 64'd1, 64'h21, 64'd2, "sllw_amt5");
        alu(ALU_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0800_0000, "srlw");
        alu(ALU_SRAW, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, "sraw");
        alu(5'd15, 64'd3, 64'd4, 64'd0, "undef15");
        alu(5'd31, 64'd3, 64'd4, 64'd0, "undef31");

        // Branches
        ALU_ctrl2 = ALU_BLT; src_a = -64'sd1; src_b = 64'd1; Brch2 = 1'b1;
        PC4 = 64'h8000_0000; BImm2 = 12'h004; reg_w_en2 = 1'b0; valid4 = 1'b1;
        #1;
        chk("blt_taken", brch_taken, 1'b1);
        chk("blt_target", brch_target, 64'h8000_0008);
        tick();
        chk("blt_res", result, 64'd0);
        chk("blt_rwen", reg_w_en3_, 1'b0);
        ALU_ctrl2 = ALU_BGE; BImm2 = 12'hFFE;
        #1;
        chk("bge_taken", brch_taken, 1'b0);
        chk("bge_target", brch_target, 64'h7FFF_FFFC);
        tick();
        ALU_ctrl2 = ALU_BEQ; src_a = 64'd9; src_b = 64'd9; valid4 = 1'b0;
        #1;
        chk("beq_noval", brch_taken, 1'b0);
        valid4 = 1'b1;
        #1;
        chk("beq_taken", brch_taken, 1'b1);
        tick();
        ready5 = 1'b0;
        #1;
        chk("beq_stalled", brch_taken, 1'b0);
        Brch2 = 1'b0; valid4 = 1'b0; ready5 = 1'b1;
        tick();
        chk("drain_v", valid5, 1'b0);

        // Backpressure
        alu(ALU_ADD, 64'd100, 64'd0, 64'd100, "bp_first");
        PC4 = 64'h200;
        ALU_ctrl2 = ALU_XOR; src_a = 64'd3; src_b = 64'd5; valid4 = 1'b1;
        tick();
        chk("bp_load2", result, 64'd6);
        ALU_ctrl2 = ALU_ADD; src_a = 64'd40; src_b = 64'd2; PC4 = 64'h300;
        ready5 = 1'b0;
        #1;
        chk("bp_rdy0", ready4, 1'b0);
        tick();
        chk("bp_hold_res", result, 64'd6);
        chk("bp_hold_pc", PC5, 64'h200);
        chk("bp_hold_v", valid5, 1'b1);
        tick();
        chk("bp_hold_res2", result, 64'd6);
        ready5 = 1'b1;
        #1;
        chk("bp_rdy1", ready4, 1'b1);
        tick();
        valid4 = 1'b0;
        chk("bp_resume", result, 64'd42);
        chk("bp_resume_pc", PC5, 64'h300);

        // Bubble forces write enables low; normal store keeps MEM_W_en
        Ins3 = 32'd0; reg_w_en2 = 1'b1; MEM_W_en2 = 1'b1;
        alu(ALU_ADD, 64'd1, 64'd1, 64'd2, "bubble");
        chk("bubble_rwen", reg_w_en3_, 1'b0);
        chk("bubble_mwen", MEM_W_en3, 1'b0);
        Ins3 = 32'h0000_3023;
        alu(ALU_ADD, 64'd8, 64'd8, 64'd16, "store");
        chk("store_mwen", MEM_W_en3, 1'b1);
        chk("store_rwen", reg_w_en3_, 1'b1);
        MEM_W_en2 = 1'b0;
        tick();

`ifdef YSYX_22041071_MDU_EN
        mdu(ALU_DIV,  64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, "div_ovf");
        mdu(ALU_REM,  64'h8000_0000_0000_0000, -64'sd1, 64'd0, "rem_ovf");
        mdu(ALU_DIVU, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu_z");
        mdu(ALU_REM,  64'd7, 64'd0, 64'd7, "rem_z");
        mdu(ALU_MULW, 64'h1_0000_0003, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, "mulw");
        mdu(ALU_MUL,  64'd3, -64'sd5, -64'sd15, "mul");
        mdu(ALU_DIV,  -64'sd7, 64'd2, -64'sd3, "div_neg");
        mdu(ALU_REM,  -64'sd7, 64'd2, -64'sd1, "rem_neg");
        mdu(ALU_DIVW, 64'hFFFF_FFFF_8000_0000, -64'sd1, 64'hFFFF_FFFF_8000_0000, "divw_ovf");

        // Reset during DIV aborts it
        begin
            logic seen;
            ALU_ctrl2 = ALU_DIV; src_a = 64'd100; src_b = 64'd7; valid4 = 1'b1;
            tick();
            valid4 = 1'b0;
            repeat (10) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("abort_v", valid5, 1'b0);
            chk("abort_rdy", ready4, 1'b1);
            seen = 1'b0;
            repeat (80) begin
                tick();
                if (valid5 === 1'b1) seen = 1'b1;
            end
            chk("abort_noresult", seen, 1'b0);
        end
        mdu(ALU_REMU, 64'd7, 64'd3, 64'd1, "remu_after");
`else
        alu(ALU_DIV, 64'd10, 64'd2, 64'd0, "div_disabled");
        chk("div_disabled_rdy", ready4, 1'b1);
        alu(ALU_MUL, 64'd3, 64'd5, 64'd0, "mul_disabled");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
